time_keeper_ctrl: RTL and testbench
===================================

Name: time_keeper_ctrl

Overview:
- Sequencing controller for the 1 Hz clock_generator output.
- Synchronises and edge-detects clk_1Hz, then keeps 24-hour time as binary hours, minutes and seconds.
- Provides a button-driven set-mode state machine for hour and minute adjustment.
- Sits between clock_generator and the display/BCD encoding stage.

Parameters:
- HOURS_PER_DAY, 24, hour counter modulus (hours wrap HOURS_PER_DAY-1 -> 0)
- SYNC_STAGES, 2, flop depth of each input synchroniser (>= 2)

Ports:
- clk  input  1  system clock, 100 MHz, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- clk_1Hz  input  1  1 Hz square wave from clock_generator
- btn_mode  input  1  debounced level, mode-advance button
- btn_inc  input  1  debounced level, increment button
- hours  output  5  current hour, 0..HOURS_PER_DAY-1
- minutes  output  6  current minute, 0..59
- seconds  output  6  current second, 0..59
- mode  output  2  state: 0 RUN, 1 SET_HOUR, 2 SET_MIN
- blink  output  1  display flash for the field being set
- sec_pulse  output  1  one-cycle strobe per accepted second increment

Behaviour:
- Reset (reset=0, async): hours=0, minutes=0, seconds=0, mode=RUN, blink=0, sec_pulse=0, all sync/edge flops=0. Release is synchronous to clk.
- Input conditioning: clk_1Hz, btn_mode and btn_inc each pass through a SYNC_STAGES synchroniser, then a rising-edge detector.
  - This produces tick, mode_p and inc_p, each one cycle wide.
  - Falling edges are ignored.
  - A held button yields exactly one pulse.
- Latency: with SYNC_STAGES=2, an input first sampled high at edge k asserts its pulse during cycle k+2. The register update it causes is visible after edge k+3.
- FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing on mode_p only.
- RUN:
  - tick increments seconds.
  - 59 -> 0 carries to minutes; minutes 59 -> 0 carries to hours; hours HOURS_PER_DAY-1 -> 0.
  - All carries resolve in the same cycle.
  - sec_pulse=1 for that cycle.
  - inc_p is ignored.
- SET_HOUR:
  - inc_p increments hours modulo HOURS_PER_DAY, with no effect on other fields.
  - tick does not advance time and sec_pulse stays 0.
- SET_MIN:
  - inc_p increments minutes 59 -> 0 with no carry into hours.
  - tick is ignored.
- Leaving SET_MIN for RUN clears seconds to 0 in the same cycle, so time restarts at hh:mm:00.
- blink:
  - Forced 0 in RUN.
  - Toggles on every tick in SET_HOUR and SET_MIN.
  - Set to 1 on entry to either set state.
- Simultaneous events:
  - mode_p with inc_p in a set state: mode transition wins, inc_p is dropped.
  - mode_p with tick in RUN: the increment is applied and the state moves to SET_HOUR in the same edge.
  - mode_p with tick in SET_MIN: the state returns to RUN, seconds=0, and the tick is dropped.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of state or pending pulses.
- Illegal mode encoding 3 returns to RUN on the next edge with no field changes.
- Width rules: all counters are unsigned binary and never exceed their maxima. Comparisons use the full field width.

Decomposition:
- Package clock_pkg holds:
  - state enum/localparams RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2
  - SEC_MAX=59, MIN_MAX=59
  - field widths HOUR_W=5, MIN_W=6, SEC_W=6
- One sub-module, sync_edge_detect (parameter SYNC_STAGES; ports clk, reset, din, pulse), instantiated three times.
- Counters and FSM live in time_keeper_ctrl.

Test Plan:
- Rollover: load 23:59:58 via the set modes, then drive 2 clk_1Hz rising edges in RUN -> 23:59:59 then 00:00:00. sec_pulse pulses twice, each one cycle, 3 cycles after each edge.
- Set sequence: from reset, press mode, then inc ×5 -> mode=1, hours=5. Press mode, then inc ×61 -> mode=2, minutes=1, hours still 5. Press mode -> mode=0, seconds=0.
- Freeze: in SET_HOUR, apply 4 clk_1Hz edges -> seconds and minutes unchanged, sec_pulse never high, blink toggles 1 -> 0 -> 1 -> 0 -> 1.
- Simultaneity: in SET_MIN at minutes=10, assert btn_mode and btn_inc rising in the same cycle -> mode=0, minutes=10, seconds=0. In RUN, align btn_mode with a clk_1Hz edge -> seconds+1 and mode=1 on the same edge.
- Held button: hold btn_inc high 1000 cycles in SET_HOUR from hours=3 -> hours=4 only. Glitch-free one-cycle btn_mode pulse shorter than one clk period is not required to register.
- Async reset: at 12:34:56, drive reset=0 mid-cycle (between clk edges) -> all outputs 0 and mode=0 before the next clk edge. After release, the first clk_1Hz edge gives 00:00:01.

Source files
------------

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-keeping controller: controller state
// encoding, field widths, field maxima and a wrapping-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_e;

    // Increment a 6-bit field, wrapping to zero at (or, defensively, above) max.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] val,
                                             input logic [5:0] max_val);
        if (val >= max_val) begin
            return 6'd0;
        end else begin
            return val + 6'd1;
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Multi-flop synchroniser followed by a rising-edge detector. Produces a
// registered single-cycle pulse per rising edge of din; falling edges and a
// held-high level produce nothing further.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   din   - asynchronous level input
//   pulse - one-cycle strobe on each synchronised rising edge of din
// -----------------------------------------------------------------------------
module sync_edge_detect
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   pulse_q;
    logic                   pulse_d;

    // Next-state for synchroniser shift chain, history flop and edge pulse.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchroniser, history and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/time_keeper_ctrl.sv
// -----------------------------------------------------------------------------
// time_keeper_ctrl
// Keeps 24-hour binary time from a 1 Hz square wave and provides a
// button-driven set mode (RUN -> SET_HOUR -> SET_MIN -> RUN).
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   clk_1Hz   - 1 Hz square wave (asynchronous)
//   btn_mode  - debounced mode-advance button level
//   btn_inc   - debounced increment button level
//   hours     - current hour 0..HOURS_PER_DAY-1
//   minutes   - current minute 0..59
//   seconds   - current second 0..59
//   mode      - 0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink     - flash enable for the field being set
//   sec_pulse - one-cycle strobe per accepted second increment
// -----------------------------------------------------------------------------
module time_keeper_ctrl
    import clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_1Hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [1:0]        mode,
    output logic              blink,
    output logic              sec_pulse
);

    localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOURS_PER_DAY - 1);

    logic tick_s;
    logic mode_p_s;
    logic inc_p_s;

    state_e            state_q,     state_d;
    logic [HOUR_W-1:0] hours_q,     hours_d;
    logic [MIN_W-1:0]  minutes_q,   minutes_d;
    logic [SEC_W-1:0]  seconds_q,   seconds_d;
    logic              blink_q,     blink_d;
    logic              sec_pulse_q, sec_pulse_d;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .clk   (clk),
        .reset (reset),
        .din   (clk_1Hz),
        .pulse (tick_s)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
        .clk   (clk),
        .reset (reset),
        .din   (btn_mode),
        .pulse (mode_p_s)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
        .clk   (clk),
        .reset (reset),
        .din   (btn_inc),
        .pulse (inc_p_s)
    );

    // Next-state: mode FSM, time counters with carries, blink and second strobe.
    always_comb begin
        state_d     = state_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        blink_d     = blink_q;
        sec_pulse_d = 1'b0;

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                // A tick coinciding with mode_p is still counted.
                if (tick_s) begin
                    sec_pulse_d = 1'b1;
                    seconds_d   = wrap_inc6(seconds_q, SEC_MAX);
                    if (seconds_q >= SEC_MAX) begin
                        minutes_d = wrap_inc6(minutes_q, MIN_MAX);
                        if (minutes_q >= MIN_MAX) begin
                            hours_d = (hours_q >= HOUR_MAX) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            hours_d = hours_q;
                        end
                    end else begin
                        minutes_d = minutes_q;
                    end
                end else begin
                    sec_pulse_d = 1'b0;
                end
                if (mode_p_s) begin
                    state_d = SET_HOUR;
                    blink_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            SET_HOUR: begin
                // Mode advance takes priority; a coincident inc is dropped.
                if (mode_p_s) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (inc_p_s) begin
                        hours_d = (hours_q >= HOUR_MAX) ? 5'd0 : hours_q + 5'd1;
                    end else begin
                        hours_d = hours_q;
                    end
                    if (tick_s) begin
                        blink_d = ~blink_q;
                    end else begin
                        blink_d = blink_q;
                    end
                end
            end
            SET_MIN: begin
                // Returning to RUN restarts the minute at :00; tick and inc dropped.
                if (mode_p_s) begin
                    state_d   = RUN;
                    seconds_d = 6'd0;
                    blink_d   = 1'b0;
                end else begin
                    if (inc_p_s) begin
                        minutes_d = wrap_inc6(minutes_q, MIN_MAX);
                    end else begin
                        minutes_d = minutes_q;
                    end
                    if (tick_s) begin
                        blink_d = ~blink_q;
                    end else begin
                        blink_d = blink_q;
                    end
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    // State, time and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            hours_q     <= 5'd0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            blink_q     <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            blink_q     <= blink_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign mode      = state_q;
    assign blink     = blink_q;
    assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_keeper_ctrl
// Directed self-checking bench for time_keeper_ctrl.
// -----------------------------------------------------------------------------
module tb_time_keeper_ctrl;

    logic       clk;
    logic       reset;
    logic       clk_1Hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    int total_cnt;
    int bad_cnt;
    int sp_cnt;

    time_keeper_ctrl #(.HOURS_PER_DAY(24), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_1Hz   (clk_1Hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .mode      (mode),
        .blink     (blink),
        .sec_pulse (sec_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with sec_pulse high, sampled away from the active edge.
    always @(negedge clk) begin
        if (sec_pulse) sp_cnt <= sp_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Raise the selected inputs {mode, inc, tick}, hold, then drop and settle.
    task automatic drive(input logic [2:0] sel, input int hold);
        @(negedge clk);
        btn_mode = sel[2];
        btn_inc  = sel[1];
        clk_1Hz  = sel[0];
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        clk_1Hz  = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic press_mode();
        drive(3'b100, 5);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) drive(3'b010, 5);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(3'b001, 5);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, int'(hours), h);
        chk({tag, ".m"}, int'(minutes), m);
        chk({tag, ".s"}, int'(seconds), s);
    endtask

    initial begin
        int sp0;
        total_cnt = 0;
        bad_cnt   = 0;
        sp_cnt    = 0;
        reset     = 1'b0;
        clk_1Hz   = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_time("rst", 0, 0, 0);
        chk("rst.mode", int'(mode), 0);
        chk("rst.blink", int'(blink), 0);
        chk("rst.sp", int'(sec_pulse), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Set sequence
        press_mode();
        chk("set.mode1", int'(mode), 1);
        chk("set.blink1", int'(blink), 1);
        press_inc(5);
        chk("set.h5", int'(hours), 5);
        press_mode();
        chk("set.mode2", int'(mode), 2);
        press_inc(61);
        chk("set.m1", int'(minutes), 1);
        chk("set.h5b", int'(hours), 5);
        press_mode();
        chk("set.mode0", int'(mode), 0);
        chk_time("set.t", 5, 1, 0);
        chk("set.nosp", sp_cnt, 0);

        // Freeze in SET_HOUR with blink toggling
        press_mode();
        chk("frz.blink0", int'(blink), 1);
        sp0 = sp_cnt;
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            chk("frz.blink", int'(blink), (i % 2 == 0) ? 0 : 1);
        end
        chk_time("frz.t", 5, 1, 0);
        chk("frz.nosp", sp_cnt - sp0, 0);

        // Held button: hours 5 -> 3 by wrapping, then hold inc for 1000 cycles
        press_inc(22);
        chk("hold.h3", int'(hours), 3);
        drive(3'b010, 1000);
        chk("hold.h4", int'(hours), 4);

        // Load 23:59:58
        press_inc(19);
        press_mode();
        press_inc(58);
        press_mode();
        chk("roll.mode", int'(mode), 0);
        ticks(58);
        chk_time("roll.pre", 23, 59, 58);

        // Rollover with exact pulse latency
        sp0 = sp_cnt;
        @(negedge clk);
        clk_1Hz = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("lat.sp_early", int'(sec_pulse), 0);
        chk("lat.s_early", int'(seconds), 58);
        @(posedge clk);
        #1;
        chk("lat.sp", int'(sec_pulse), 1);
        chk("lat.s59", int'(seconds), 59);
        @(posedge clk);
        #1;
        chk("lat.sp_off", int'(sec_pulse), 0);
        repeat (5) @(negedge clk);
        clk_1Hz = 1'b0;
        repeat (5) @(negedge clk);
        ticks(1);
        chk_time("roll.wrap", 0, 0, 0);
        chk("roll.spcnt", sp_cnt - sp0, 2);

        // Simultaneity in SET_MIN: mode wins over inc, seconds cleared
        ticks(1);
        chk("sim.s1", int'(seconds), 1);
        press_mode();
        press_mode();
        press_inc(10);
        chk("sim.m10", int'(minutes), 10);
        drive(3'b110, 5);
        chk("sim.mode0", int'(mode), 0);
        chk_time("sim.t", 0, 10, 0);

        // Simultaneity in RUN: tick counted and mode advances together
        sp0 = sp_cnt;
        drive(3'b101, 5);
        chk("simr.mode1", int'(mode), 1);
        chk("simr.s1", int'(seconds), 1);
        chk("simr.sp", sp_cnt - sp0, 1);

        // Load 12:34:56
        press_inc(12);
        press_mode();
        press_inc(24);
        press_mode();
        ticks(56);
        chk_time("ar.pre", 12, 34, 56);

        // Async reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_time("ar.now", 0, 0, 0);
        chk("ar.mode", int'(mode), 0);
        chk("ar.blink", int'(blink), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        ticks(1);
        chk_time("ar.post", 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
